is_queue: RTL and testbench

- Parametrised successor of the dual-issue stage.
- Circular issue queue of configurable depth sits between decode and two execute units (EU0 general, EU1 ALU-only).
- Issues in order: up to two entries per cycle from the queue head.
- Per-register scoreboard uses tagged completions, so several results can be outstanding per EU. RAW and WAW hazards both stall.

---
 rtl/is_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_is_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/is_queue.sv
// is_queue: circular in-order issue queue feeding EU0 (general) and EU1 (ALU-only),
// up to two issues per cycle gated by a tagged-completion scoreboard. Optional: ISSUE_PERF_EN.

module is_queue_chk (
    input  logic [31:0] i_sb,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rj,
    input  logic [4:0]  i_rk,
    output logic        o_ok
);
    assign o_ok = i_sb[i_rd] & i_sb[i_rj] & i_sb[i_rk];
endmodule

module is_queue #(
    parameter int DEPTH = 16,
    parameter int PAY_W = 128,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid0,
    input  logic             in_valid1,
    input  logic             in_alu0,
    input  logic             in_alu1,
    input  logic [4:0]       in_rd0,
    input  logic [4:0]       in_rj0,
    input  logic [4:0]       in_rk0,
    input  logic [4:0]       in_rd1,
    input  logic [4:0]       in_rj1,
    input  logic [4:0]       in_rk1,
    input  logic [PAY_W-1:0] in_pay0,
    input  logic [PAY_W-1:0] in_pay1,
    output logic [1:0]       num_read,
    output logic [CNT_W-1:0] occupancy,
    output logic             eu0_en,
    output logic             eu1_en,
    input  logic             eu0_ready,
    input  logic             eu1_ready,
    output logic [4:0]       eu0_rd,
    output logic [4:0]       eu0_rj,
    output logic [4:0]       eu0_rk,
    output logic [4:0]       eu1_rd,
    output logic [4:0]       eu1_rj,
    output logic [4:0]       eu1_rk,
    output logic [PAY_W-1:0] eu0_pay,
    output logic [PAY_W-1:0] eu1_pay,
    input  logic             eu0_finish,
    input  logic             eu1_finish,
    input  logic [4:0]       eu0_finish_rd,
    input  logic [4:0]       eu1_finish_rd
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_dual,
    output logic [31:0]      perf_single,
    output logic [31:0]      perf_stall
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic             alu;
        logic [4:0]       rd;
        logic [4:0]       rj;
        logic [4:0]       rk;
        logic [PAY_W-1:0] pay;
    } entry_t;

    entry_t           r_q [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;
    logic [31:0]      r_sb;

    entry_t           w_ent_a, w_ent_b, w_in0, w_in1, w_eu0_ent, w_eu1_ent;
    logic [PTR_W-1:0] w_head1, w_tail1;
    logic [31:0]      w_fin_set, w_sb_fin, w_a_clr, w_b_clr, w_iss_clr;
    logic [1:0][31:0] w_chk_sb;
    logic [1:0][4:0]  w_c_rd, w_c_rj, w_c_rk;
    logic [1:0]       w_c_ok;
    logic             w_a_vld, w_b_vld, w_a_iss, w_a_eu1, w_b_iss;
    logic             w_en0, w_en1, w_wr0, w_wr1;
    logic [1:0]       w_issued, w_written, w_grant;
    logic [CNT_W:0]   w_free;

    assign w_head1 = r_head + PTR_W'(1);
    assign w_ent_a = r_q[r_head];
    assign w_ent_b = r_q[w_head1];
    assign w_a_vld = (r_occ != '0);
    assign w_b_vld = (r_occ >= CNT_W'(2));

    always_comb begin
        w_fin_set = '0;
        if (eu0_finish) w_fin_set[eu0_finish_rd] = 1'b1;
        if (eu1_finish) w_fin_set[eu1_finish_rd] = 1'b1;
    end

    // Completions are visible to this cycle's issue decision; flush ignores them.
    assign w_sb_fin = r_sb | (flush ? 32'h0 : w_fin_set);

    always_comb begin
        w_a_clr = '0;
        w_b_clr = '0;
        w_a_clr[w_ent_a.rd] = 1'b1;
        w_b_clr[w_ent_b.rd] = 1'b1;
        w_a_clr[0] = 1'b0;
        w_b_clr[0] = 1'b0;
    end

    // B sees A's destination already claimed, so same-cycle RAW/WAW block it.
    assign w_chk_sb = {w_sb_fin & ~w_a_clr, w_sb_fin};
    assign w_c_rd   = {w_ent_b.rd, w_ent_a.rd};
    assign w_c_rj   = {w_ent_b.rj, w_ent_a.rj};
    assign w_c_rk   = {w_ent_b.rk, w_ent_a.rk};

    for (genvar g = 0; g < 2; g++) begin : g_chk
        is_queue_chk u_chk (
            .i_sb (w_chk_sb[g]),
            .i_rd (w_c_rd[g]),
            .i_rj (w_c_rj[g]),
            .i_rk (w_c_rk[g]),
            .o_ok (w_c_ok[g])
        );
    end

    always_comb begin
        w_a_iss = 1'b0;
        w_a_eu1 = 1'b0;
        w_b_iss = 1'b0;
        if (!flush && w_a_vld && w_c_ok[0]) begin
            if (w_ent_a.alu && eu1_ready) begin
                w_a_iss = 1'b1;
                w_a_eu1 = 1'b1;
            end else if (eu0_ready) begin
                w_a_iss = 1'b1;
            end
        end
        if (w_a_iss && w_b_vld && w_c_ok[1]) begin
            if (w_a_eu1) w_b_iss = eu0_ready;
            else         w_b_iss = eu1_ready & w_ent_b.alu;
        end
    end

    assign w_en0 = (w_a_iss & ~w_a_eu1) | (w_b_iss &  w_a_eu1);
    assign w_en1 = (w_a_iss &  w_a_eu1) | (w_b_iss & ~w_a_eu1);

    // Idle lanes drive zeros so stale or unwritten entries never reach the EUs.
    always_comb begin
        w_eu0_ent = w_a_eu1 ? w_ent_b : w_ent_a;
        w_eu1_ent = w_a_eu1 ? w_ent_a : w_ent_b;
        if (!w_en0) w_eu0_ent = '0;
        if (!w_en1) w_eu1_ent = '0;
    end

    assign eu0_en  = w_en0;
    assign eu1_en  = w_en1;
    assign eu0_rd  = w_eu0_ent.rd;
    assign eu0_rj  = w_eu0_ent.rj;
    assign eu0_rk  = w_eu0_ent.rk;
    assign eu0_pay = w_eu0_ent.pay;
    assign eu1_rd  = w_eu1_ent.rd;
    assign eu1_rj  = w_eu1_ent.rj;
    assign eu1_rk  = w_eu1_ent.rk;
    assign eu1_pay = w_eu1_ent.pay;

    assign w_issued  = {1'b0, w_a_iss} + {1'b0, w_b_iss};
    assign w_iss_clr = (w_a_iss ? w_a_clr : 32'h0) | (w_b_iss ? w_b_clr : 32'h0);
    assign w_free    = (CNT_W+1)'(DEPTH) - ({1'b0, r_occ} - (CNT_W+1)'(w_issued));

    always_comb begin
        w_grant = 2'b00;
        if (rstn && !flush) begin
            if (w_free >= (CNT_W+1)'(2))      w_grant = 2'b11;
            else if (w_free == (CNT_W+1)'(1)) w_grant = 2'b01;
        end
    end

    assign num_read  = w_grant;
    assign occupancy = r_occ;

    assign w_wr0     = in_valid0 & w_grant[0];
    assign w_wr1     = in_valid1 & w_grant[1];
    assign w_written = {1'b0, w_wr0} + {1'b0, w_wr1};
    assign w_tail1   = r_tail + PTR_W'(w_wr0);
    assign w_in0     = '{alu: in_alu0, rd: in_rd0, rj: in_rj0, rk: in_rk0, pay: in_pay0};
    assign w_in1     = '{alu: in_alu1, rd: in_rd1, rj: in_rj1, rk: in_rk1, pay: in_pay1};

    always_ff @(posedge clk) begin
        if (w_wr0) r_q[r_tail]  <= w_in0;
        if (w_wr1) r_q[w_tail1] <= w_in1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_sb   <= '1;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_sb   <= '1;
        end else begin
            r_head <= r_head + PTR_W'(w_issued);
            r_tail <= r_tail + PTR_W'(w_written);
            r_occ  <= r_occ - CNT_W'(w_issued) + CNT_W'(w_written);
            // Issue clear wins over a same-cycle finish on the same register.
            r_sb   <= (w_sb_fin & ~w_iss_clr) | 32'h1;
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] r_perf_dual, r_perf_single, r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_dual   <= '0;
            r_perf_single <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_issued == 2'd2 && r_perf_dual != '1)
                r_perf_dual <= r_perf_dual + 32'd1;
            if (w_issued == 2'd1 && r_perf_single != '1)
                r_perf_single <= r_perf_single + 32'd1;
            if (w_issued == 2'd0 && r_occ != '0 && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_dual   = r_perf_dual;
    assign perf_single = r_perf_single;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_is_queue.sv
// tb_is_queue: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_is_queue;
    localparam int DEPTH = 4;
    localparam int PAY_W = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic             in_valid0 = 0, in_valid1 = 0, in_alu0 = 0, in_alu1 = 0;
    logic [4:0]       in_rd0 = 0, in_rj0 = 0, in_rk0 = 0, in_rd1 = 0, in_rj1 = 0, in_rk1 = 0;
    logic [PAY_W-1:0] in_pay0 = 0, in_pay1 = 0;
    logic [1:0]       num_read;
    logic [CNT_W-1:0] occupancy;
    logic             eu0_en, eu1_en;
    logic             eu0_ready = 0, eu1_ready = 0;
    logic [4:0]       eu0_rd, eu0_rj, eu0_rk, eu1_rd, eu1_rj, eu1_rk;
    logic [PAY_W-1:0] eu0_pay, eu1_pay;
    logic             eu0_finish = 0, eu1_finish = 0;
    logic [4:0]       eu0_finish_rd = 0, eu1_finish_rd = 0;
`ifdef ISSUE_PERF_EN
    logic [31:0]      perf_dual, perf_single, perf_stall;
`endif

    int n_run = 0, n_fail = 0;

    is_queue #(.DEPTH(DEPTH), .PAY_W(PAY_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_alu0(in_alu0), .in_alu1(in_alu1),
        .in_rd0(in_rd0), .in_rj0(in_rj0), .in_rk0(in_rk0),
        .in_rd1(in_rd1), .in_rj1(in_rj1), .in_rk1(in_rk1),
        .in_pay0(in_pay0), .in_pay1(in_pay1),
        .num_read(num_read), .occupancy(occupancy),
        .eu0_en(eu0_en), .eu1_en(eu1_en), .eu0_ready(eu0_ready), .eu1_ready(eu1_ready),
        .eu0_rd(eu0_rd), .eu0_rj(eu0_rj), .eu0_rk(eu0_rk),
        .eu1_rd(eu1_rd), .eu1_rj(eu1_rj), .eu1_rk(eu1_rk),
        .eu0_pay(eu0_pay), .eu1_pay(eu1_pay),
        .eu0_finish(eu0_finish), .eu1_finish(eu1_finish),
        .eu0_finish_rd(eu0_finish_rd), .eu1_finish_rd(eu1_finish_rd)
`ifdef ISSUE_PERF_EN
        , .perf_dual(perf_dual), .perf_single(perf_single), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain queue of entries plus a 32-entry "register ready" array.
    typedef struct {
        bit             alu;
        bit [4:0]       rd;
        bit [4:0]       rj;
        bit [4:0]       rk;
        bit [PAY_W-1:0] pay;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] msb;
    int        m_pd, m_ps, m_pst;
    bit        x_en0, x_en1;
    ent_t      x_e0, x_e1;
    bit [1:0]  x_nr;
    int        x_iss;

    function automatic void model_reset();
        mq.delete();
        msb = '1;
        m_pd = 0; m_ps = 0; m_pst = 0;
    endfunction

    function automatic bool_ready(input bit [31:0] sb, input ent_t e);
        return sb[e.rj] && sb[e.rk] && sb[e.rd];
    endfunction

    function automatic void model_comb();
        bit [31:0] sb = msb;
        bit a_eu1 = 0;
        int free;
        x_en0 = 0; x_en1 = 0; x_iss = 0; x_nr = 0;
        x_e0 = '{default: 0}; x_e1 = '{default: 0};
        if (!flush) begin
            if (eu0_finish) sb[eu0_finish_rd] = 1;
            if (eu1_finish) sb[eu1_finish_rd] = 1;
            if (mq.size() >= 1 && bool_ready(sb, mq[0])) begin
                if (mq[0].alu && eu1_ready) begin
                    x_en1 = 1; x_e1 = mq[0]; a_eu1 = 1; x_iss = 1;
                end else if (eu0_ready) begin
                    x_en0 = 1; x_e0 = mq[0]; x_iss = 1;
                end
            end
            if (x_iss == 1 && mq.size() >= 2) begin
                if (mq[0].rd != 0) sb[mq[0].rd] = 0;
                if (bool_ready(sb, mq[1])) begin
                    if (a_eu1 && eu0_ready) begin
                        x_en0 = 1; x_e0 = mq[1]; x_iss = 2;
                    end else if (!a_eu1 && eu1_ready && mq[1].alu) begin
                        x_en1 = 1; x_e1 = mq[1]; x_iss = 2;
                    end
                end
            end
            free = DEPTH - (mq.size() - x_iss);
            x_nr = (free >= 2) ? 2'b11 : (free == 1) ? 2'b01 : 2'b00;
        end
    endfunction

    function automatic void model_tick();
        int n = mq.size();
        if (x_iss == 2) m_pd++;
        else if (x_iss == 1) m_ps++;
        else if (n > 0) m_pst++;
        if (flush) begin
            mq.delete();
            msb = '1;
            return;
        end
        if (eu0_finish) msb[eu0_finish_rd] = 1;
        if (eu1_finish) msb[eu1_finish_rd] = 1;
        if (x_en0 && x_e0.rd != 0) msb[x_e0.rd] = 0;
        if (x_en1 && x_e1.rd != 0) msb[x_e1.rd] = 0;
        msb[0] = 1;
        for (int i = 0; i < x_iss; i++) void'(mq.pop_front());
        if (x_nr[0] && in_valid0)
            mq.push_back('{alu: in_alu0, rd: in_rd0, rj: in_rj0, rk: in_rk0, pay: in_pay0});
        if (x_nr[1] && in_valid1)
            mq.push_back('{alu: in_alu1, rd: in_rd1, rj: in_rj1, rk: in_rk1, pay: in_pay1});
    endfunction

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic put(input bit v0, input bit a0, input bit [4:0] d0, input bit [4:0] j0,
                       input bit [4:0] k0, input bit v1, input bit a1, input bit [4:0] d1,
                       input bit [4:0] j1, input bit [4:0] k1);
        in_valid0 = v0; in_alu0 = a0; in_rd0 = d0; in_rj0 = j0; in_rk0 = k0;
        in_valid1 = v1; in_alu1 = a1; in_rd1 = d1; in_rj1 = j1; in_rk1 = k1;
        in_pay0 = PAY_W'($urandom);
        in_pay1 = PAY_W'($urandom);
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fin(input bit f0, input bit [4:0] r0, input bit f1, input bit [4:0] r1);
        eu0_finish = f0; eu0_finish_rd = r0;
        eu1_finish = f1; eu1_finish_rd = r1;
    endtask

    task automatic do_reset();
        rstn = 0; flush = 0; idle(); fin(0, 0, 0, 0);
        eu0_ready = 0; eu1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rstn = 0; idle(); fin(0, 0, 0, 0); eu0_ready = 0; eu1_ready = 0;
        @(posedge clk); #1;
        n_run++; if (occupancy !== 0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_run++; if (num_read !== 2'b00) begin n_fail++; $display("FAIL reset_num_read got %b want 00", num_read); end
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL reset_en got %b want 00", {eu0_en, eu1_en}); end
        @(negedge clk); rstn = 1; model_reset();
        put(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
        #1;
        n_run++; if (num_read !== 2'b11) begin n_fail++; $display("FAIL empty_num_read got %b want 11", num_read); end
        tick(); idle(); #1;
        n_run++; if (occupancy !== 2) begin n_fail++; $display("FAIL prereset_occ got %0d want 2", occupancy); end
        #1 rstn = 0; #1;
        n_run++; if (occupancy !== 0) begin n_fail++; $display("FAIL async_reset_occ got %0d want 0", occupancy); end
        n_run++; if (num_read !== 2'b00) begin n_fail++; $display("FAIL async_reset_nr got %b want 00", num_read); end
        @(negedge clk); rstn = 1; model_reset();
    endtask

    task automatic test_dual_alu();
        do_reset();
        eu0_ready = 1; eu1_ready = 1;
        put(1, 1, 1, 0, 0, 1, 1, 2, 0, 0); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL dual_empty_en got %b want 00", {eu0_en, eu1_en}); end
        tick(); idle(); #1;
        n_run++; if (occupancy !== 2) begin n_fail++; $display("FAIL dual_occ got %0d want 2", occupancy); end
        n_run++; if (eu1_en !== 1'b1 || eu1_rd !== 5'd1) begin n_fail++; $display("FAIL dual_eu1 got en=%b rd=%0d want en=1 rd=1", eu1_en, eu1_rd); end
        n_run++; if (eu0_en !== 1'b1 || eu0_rd !== 5'd2) begin n_fail++; $display("FAIL dual_eu0 got en=%b rd=%0d want en=1 rd=2", eu0_en, eu0_rd); end
        tick(); #1;
        n_run++; if (occupancy !== 0) begin n_fail++; $display("FAIL dual_drain_occ got %0d want 0", occupancy); end
        // consumer of r1,r2 must wait for both writebacks
        put(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        tick(); idle(); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL sb_cleared_en got %b want 00", {eu0_en, eu1_en}); end
        fin(0, 0, 1, 1); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL sb_partial_en got %b want 00", {eu0_en, eu1_en}); end
        tick(); fin(1, 2, 0, 0); #1;
        n_run++; if (eu1_en !== 1'b1) begin n_fail++; $display("FAIL sb_bypass_en got %b want 1", eu1_en); end
        tick(); fin(0, 0, 0, 0);
    endtask

    task automatic test_raw();
        do_reset();
        eu0_ready = 1; eu1_ready = 1;
        put(1, 1, 3, 0, 0, 1, 1, 4, 3, 0);
        tick(); idle(); #1;
        n_run++; if (eu1_en !== 1'b1 || eu1_rd !== 5'd3) begin n_fail++; $display("FAIL raw_first got en=%b rd=%0d want en=1 rd=3", eu1_en, eu1_rd); end
        n_run++; if (eu0_en !== 1'b0) begin n_fail++; $display("FAIL raw_same_cycle got %b want 0", eu0_en); end
        tick(); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL raw_wait got %b want 00", {eu0_en, eu1_en}); end
        n_run++; if (occupancy !== 1) begin n_fail++; $display("FAIL raw_occ got %0d want 1", occupancy); end
        fin(1, 3, 0, 0); #1;
        n_run++; if (eu1_en !== 1'b1 || eu1_rj !== 5'd3) begin n_fail++; $display("FAIL raw_bypass got en=%b rj=%0d want en=1 rj=3", eu1_en, eu1_rj); end
        tick(); fin(0, 0, 0, 0);
    endtask

    task automatic test_full();
        do_reset();
        put(1, 0, 1, 0, 0, 1, 0, 2, 0, 0); #1;
        n_run++; if (num_read !== 2'b11) begin n_fail++; $display("FAIL full_nr0 got %b want 11", num_read); end
        tick(); put(1, 0, 3, 0, 0, 1, 0, 4, 0, 0); #1;
        n_run++; if (num_read !== 2'b11) begin n_fail++; $display("FAIL full_nr1 got %b want 11", num_read); end
        tick(); put(1, 0, 5, 0, 0, 1, 0, 6, 0, 0); #1;
        n_run++; if (num_read !== 2'b00 || occupancy !== 4) begin n_fail++; $display("FAIL full_nr2 got nr=%b occ=%0d want nr=00 occ=4", num_read, occupancy); end
        tick(); #1;
        n_run++; if (occupancy !== 4) begin n_fail++; $display("FAIL full_hold_occ got %0d want 4", occupancy); end
        eu0_ready = 1; #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b10 || num_read !== 2'b01) begin n_fail++; $display("FAIL full_single got en=%b nr=%b want en=10 nr=01", {eu0_en, eu1_en}, num_read); end
        tick(); idle(); #1;
        n_run++; if (occupancy !== 4) begin n_fail++; $display("FAIL full_refill_occ got %0d want 4", occupancy); end
    endtask

    task automatic test_nonalu_b();
        do_reset();
        eu0_ready = 1; eu1_ready = 0;
        put(1, 1, 1, 0, 0, 1, 0, 2, 0, 0);
        tick(); idle(); #1;
        n_run++; if (eu0_en !== 1'b1 || eu0_rd !== 5'd1 || eu1_en !== 1'b0) begin n_fail++; $display("FAIL nonalu_b_c1 got en0=%b rd=%0d en1=%b want 1 1 0", eu0_en, eu0_rd, eu1_en); end
        tick(); #1;
        n_run++; if (eu0_en !== 1'b1 || eu0_rd !== 5'd2) begin n_fail++; $display("FAIL nonalu_b_c2 got en0=%b rd=%0d want 1 2", eu0_en, eu0_rd); end
        tick(); #1;
        n_run++; if (occupancy !== 0) begin n_fail++; $display("FAIL nonalu_b_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        do_reset();
        eu0_ready = 1; eu1_ready = 1;
        put(1, 1, 5, 0, 0, 1, 1, 6, 0, 0);
        tick(); put(1, 1, 7, 5, 0, 1, 1, 8, 0, 6); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b11) begin n_fail++; $display("FAIL flush_pre_issue got %b want 11", {eu0_en, eu1_en}); end
        tick(); put(1, 1, 9, 0, 0, 0, 0, 0, 0, 0); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b00) begin n_fail++; $display("FAIL flush_blocked got %b want 00", {eu0_en, eu1_en}); end
        tick(); flush = 1; fin(1, 5, 1, 6); put(1, 1, 10, 0, 0, 1, 1, 11, 0, 0); #1;
        n_run++; if (occupancy !== 3) begin n_fail++; $display("FAIL flush_occ3 got %0d want 3", occupancy); end
        n_run++; if ({eu0_en, eu1_en, num_read} !== 4'b0000) begin n_fail++; $display("FAIL flush_outputs got %b want 0000", {eu0_en, eu1_en, num_read}); end
        n_run++; if ($isunknown({eu0_en, eu1_en, num_read, occupancy, eu0_rd, eu0_rj, eu0_rk, eu1_rd, eu1_rj, eu1_rk, eu0_pay, eu1_pay})) begin n_fail++; $display("FAIL flush_x got unknown want known"); end
        tick(); flush = 0; fin(0, 0, 0, 0); put(1, 1, 0, 5, 6, 1, 1, 12, 7, 8); #1;
        n_run++; if (occupancy !== 0) begin n_fail++; $display("FAIL flush_after_occ got %0d want 0", occupancy); end
        tick(); idle(); #1;
        n_run++; if ({eu0_en, eu1_en} !== 2'b11) begin n_fail++; $display("FAIL flush_sb_valid got %b want 11", {eu0_en, eu1_en}); end
        tick();
    endtask

`ifdef ISSUE_PERF_EN
    task automatic test_perf();
        do_reset();
        put(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            eu0_ready = i[0]; eu1_ready = i[0];
            if (i[0]) put(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
            else idle();
            tick();
        end
        #1;
        n_run++; if (perf_dual !== 32'd5) begin n_fail++; $display("FAIL perf_dual got %0d want 5", perf_dual); end
        n_run++; if (perf_stall !== 32'd5) begin n_fail++; $display("FAIL perf_stall got %0d want 5", perf_stall); end
        n_run++; if (perf_single !== 32'd0) begin n_fail++; $display("FAIL perf_single got %0d want 0", perf_single); end
    endtask
`endif

    task automatic test_random();
        bit v0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            v0 = ($urandom_range(3) != 0);
            put(v0, $urandom_range(1), 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                v0 && $urandom_range(1), $urandom_range(1), 5'($urandom_range(7)),
                5'($urandom_range(7)), 5'($urandom_range(7)));
            eu0_ready = ($urandom_range(3) != 0);
            eu1_ready = ($urandom_range(3) != 0);
            fin($urandom_range(9) < 3, 5'($urandom_range(1, 7)), $urandom_range(9) < 3, 5'($urandom_range(1, 7)));
            flush = ($urandom_range(49) == 0);
            #1;
            model_comb();
            n_run++; if ({eu0_en, eu1_en} !== {x_en0, x_en1}) begin n_fail++; $display("FAIL rnd_en c%0d got %b want %b", c, {eu0_en, eu1_en}, {x_en0, x_en1}); end
            n_run++; if (num_read !== x_nr) begin n_fail++; $display("FAIL rnd_num_read c%0d got %b want %b", c, num_read, x_nr); end
            n_run++; if (occupancy !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, mq.size()); end
            if (x_en0) begin
                n_run++; if ({eu0_rd, eu0_rj, eu0_rk, eu0_pay} !== {x_e0.rd, x_e0.rj, x_e0.rk, x_e0.pay}) begin n_fail++; $display("FAIL rnd_eu0_fields c%0d got %h want %h", c, {eu0_rd, eu0_rj, eu0_rk, eu0_pay}, {x_e0.rd, x_e0.rj, x_e0.rk, x_e0.pay}); end
            end
            if (x_en1) begin
                n_run++; if ({eu1_rd, eu1_rj, eu1_rk, eu1_pay} !== {x_e1.rd, x_e1.rj, x_e1.rk, x_e1.pay}) begin n_fail++; $display("FAIL rnd_eu1_fields c%0d got %h want %h", c, {eu1_rd, eu1_rj, eu1_rk, eu1_pay}, {x_e1.rd, x_e1.rj, x_e1.rk, x_e1.pay}); end
            end
            tick();
        end
        flush = 0; idle(); fin(0, 0, 0, 0);
`ifdef ISSUE_PERF_EN
        #1;
        n_run++; if ({perf_dual, perf_single, perf_stall} !== {32'(m_pd), 32'(m_ps), 32'(m_pst)}) begin n_fail++; $display("FAIL rnd_perf got %0d/%0d/%0d want %0d/%0d/%0d", perf_dual, perf_single, perf_stall, m_pd, m_ps, m_pst); end
`endif
    endtask

    initial begin
        test_reset();
        test_dual_alu();
        test_raw();
        test_full();
        test_nonalu_b();
        test_flush();
`ifdef ISSUE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
